// File: rtl/sr_flag_arbiter_if.sv
// Request/ack and flag-bank bundle shared between control agents and the SR flag arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface sr_flag_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned IDXW  = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*IDXW-1:0] idx;
  logic                 clr;
  logic [NREQ-1:0]      gnt;
  logic                 err;
  logic                 busy;
  logic [NFLAG-1:0]     flags;

  modport master (
    output req, op, idx, clr,
    input  gnt, err, busy, flags
  );

  modport slave (
    input  req, op, idx, clr,
    output gnt, err, busy, flags
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that serialises set/reset requests from NREQ agents onto a shared
// bank of NFLAG SR flags. Each operation takes one IDLE cycle and one APPLY cycle.
module sr_flag_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned IDXW  = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  sr_flag_arbiter_if.slave bus
);
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {StIdle, StApply} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  win_q, win_d;
  logic             op_q, op_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [NFLAG-1:0] flags_q, flags_d;

  logic [PtrW-1:0]  pick;
  logic             found;
  logic             in_range;
  logic [NFLAG-1:0] set_v, rst_v;
  logic [NREQ-1:0]  gnt;
  logic             err;
  logic             busy;
  logic [IDXW-1:0]  idx_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_idx
    assign idx_arr[g] = bus.idx[g*IDXW +: IDXW];
  end

  // First requesting agent at or after ptr_q, wrapping modulo NREQ.
  always_comb begin : pick_winner
    logic [PtrW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PtrW'((32'(ptr_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign in_range = 32'(idx_q) < NFLAG;

  always_comb begin : fsm_next
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    idx_d   = idx_q;
    gnt     = '0;
    err     = 1'b0;
    busy    = 1'b0;
    set_v   = '0;
    rst_v   = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          op_d    = bus.op[pick];
          idx_d   = idx_arr[pick];
          state_d = StApply;
        end
      end
      StApply: begin
        busy = 1'b1;
        // A reset landing on APPLY aborts the operation, so the ack is suppressed.
        if (!rst_i) begin
          gnt[win_q] = 1'b1;
          err        = !in_range;
        end
        if (in_range) begin
          set_v[idx_q] = op_q;
          rst_v[idx_q] = !op_q;
        end
        ptr_d   = (32'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SR update: S alone sets, R alone resets, neither or both hold.
  always_comb begin : flag_next
    if (bus.clr) begin
      flags_d = '0;
    end else begin
      flags_d = (flags_q & ~(set_v ^ rst_v)) | (set_v & ~rst_v);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      flags_q <= flags_d;
    end
  end

  assign bus.gnt   = gnt;
  assign bus.err   = err;
  assign bus.busy  = busy;
  assign bus.flags = flags_q;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: an 8-flag and a 6-flag instance share stimulus and are
// compared each cycle against a transaction-level model of arbitration and the flag bank.
module tb_sr_flag_arbiter;
  localparam int NREQ = 4;
  localparam int IDXW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*IDXW-1:0] idx;
  logic                 clr;

  sr_flag_arbiter_if #(.NREQ(4), .NFLAG(8), .IDXW(3)) bus8 ();
  sr_flag_arbiter_if #(.NREQ(4), .NFLAG(6), .IDXW(3)) bus6 ();

  assign bus8.req = req;
  assign bus8.op  = op;
  assign bus8.idx = idx;
  assign bus8.clr = clr;
  assign bus6.req = req;
  assign bus6.op  = op;
  assign bus6.idx = idx;
  assign bus6.clr = clr;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8.slave)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut6 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus6.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one pending transaction plus two flag arrays.
  bit         m_apply;
  int         m_ptr;
  int         m_win;
  bit         m_op;
  int         m_idx;
  logic [7:0] m_flags [2];
  int         m_nflag [2] = '{8, 6};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    if (rst) begin
      m_apply = 1'b0;
      m_ptr   = 0;
      m_flags[0] = '0;
      m_flags[1] = '0;
    end else begin
      if (m_apply) begin
        for (int d = 0; d < 2; d++)
          if (!clr && m_idx < m_nflag[d]) m_flags[d][m_idx] = m_op;
        m_ptr   = (m_win + 1) % NREQ;
        m_apply = 1'b0;
      end else if (req != '0) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (req[c]) m_win = c;
        end
        m_op    = op[m_win];
        m_idx   = int'(idx[m_win*IDXW +: IDXW]);
        m_apply = 1'b1;
      end
      if (clr) begin
        m_flags[0] = '0;
        m_flags[1] = '0;
      end
    end
  endfunction

  task automatic check_all();
    logic [3:0] eg;
    bit         ack;
    ack = m_apply && !rst;
    eg  = ack ? 4'(1 << m_win) : 4'b0;
    check_eq("gnt8",   32'(bus8.gnt),   32'(eg));
    check_eq("gnt6",   32'(bus6.gnt),   32'(eg));
    check_eq("busy8",  32'(bus8.busy),  32'(m_apply));
    check_eq("busy6",  32'(bus6.busy),  32'(m_apply));
    check_eq("err8",   32'(bus8.err),   32'(ack && m_idx >= 8));
    check_eq("err6",   32'(bus6.err),   32'(ack && m_idx >= 6));
    check_eq("flags8", 32'(bus8.flags), 32'(m_flags[0]));
    check_eq("flags6", 32'(bus6.flags), 32'(m_flags[1][5:0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_req(input int i, input bit r, input bit o, input int x);
    req[i] = r;
    op[i]  = o;
    idx[i*IDXW +: IDXW] = 3'(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    clr = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    op  = '0;
    idx = '0;
    clr = 1'b0;
    m_apply = 1'b0;
    m_ptr = 0;
    m_win = 0;
    m_op = 1'b0;
    m_idx = 0;
    m_flags[0] = '0;
    m_flags[1] = '0;

    // 1: reset state, then a single set of flag 5 by requester 2
    do_reset();
    cycle();
    check_eq("t1_flags_rst", 32'(bus8.flags), 32'h0);
    check_eq("t1_gnt_rst",   32'(bus8.gnt),   32'h0);
    check_eq("t1_busy_rst",  32'(bus8.busy),  32'h0);
    set_req(2, 1'b1, 1'b1, 5);
    cycle();
    check_eq("t1_gnt",  32'(bus8.gnt),  32'h4);
    check_eq("t1_busy", 32'(bus8.busy), 32'h1);
    req = '0;
    cycle();
    check_eq("t1_flags", 32'(bus8.flags), 32'h20);

    // 2: all four requesters held, served in order 0..3
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, i);
    for (int k = 0; k < NREQ; k++) begin
      cycle();
      check_eq("t2_gnt", 32'(bus8.gnt), 32'(1 << k));
      if (k == NREQ - 1) req = '0;
      cycle();
      check_eq("t2_gap", 32'(bus8.gnt), 32'h0);
    end
    check_eq("t2_flags", 32'(bus8.flags), 32'h0F);

    // 3: fill all flags, then clr collides with a reset of flag 7
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, 1'b1, i);
      cycle();
      if (i == 7) req = '0;
      cycle();
    end
    check_eq("t3_full", 32'(bus8.flags), 32'hFF);
    set_req(1, 1'b1, 1'b0, 7);
    cycle();
    check_eq("t3_gnt", 32'(bus8.gnt), 32'h2);
    req = '0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check_eq("t3_cleared", 32'(bus8.flags), 32'h0);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 0);
    cycle();
    check_eq("t3_next", 32'(bus8.gnt), 32'h4);
    req = '0;
    cycle();

    // 4: out-of-range index on the 6-flag instance
    set_req(0, 1'b1, 1'b1, 7);
    cycle();
    check_eq("t4_err6", 32'(bus6.err), 32'h1);
    check_eq("t4_gnt6", 32'(bus6.gnt), 32'h1);
    req = '0;
    cycle();
    check_eq("t4_err6_off", 32'(bus6.err),   32'h0);
    check_eq("t4_flags6",   32'(bus6.flags), 32'h01);

    // 5: reset lands on the APPLY of a set to flag 4
    set_req(1, 1'b1, 1'b1, 4);
    cycle();
    rst = 1'b1;
    req = '0;
    #1;
    check_eq("t5_gnt_abort", 32'(bus8.gnt), 32'h0);
    cycle();
    rst = 1'b0;
    check_eq("t5_flags", 32'(bus8.flags), 32'h0);
    check_eq("t5_busy",  32'(bus8.busy),  32'h0);
    req = 4'b0011;
    op  = 4'b0011;
    cycle();
    check_eq("t5_ptr0", 32'(bus8.gnt), 32'h1);
    req = '0;
    cycle();

    // 6: ptr=1 with requesters 0 and 3 held -> 3,0,3,0
    do_reset();
    set_req(0, 1'b1, 1'b1, 2);
    cycle();
    req = '0;
    cycle();
    set_req(0, 1'b1, 1'b0, 2);
    set_req(3, 1'b1, 1'b1, 6);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("t6_alt", 32'(bus8.gnt), (k % 2 == 0) ? 32'h8 : 32'h1);
      cycle();
    end
    req = '0;
    cycle();

    // Randomised traffic obeying the hold-until-gnt handshake
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NREQ; i++) begin
        bit served;
        served = m_apply && (m_win == i);
        if ((req[i] && served) || !req[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
          else if (served)
            req[i] = 1'b0;
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
